// File: rtl/bus_seq_pkg.sv
// Shared opcodes, sequencer state encoding and step counts for bus_transfer_sequencer.
package bus_seq_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  // The state value doubles as the 1-based step number of the running instruction.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP1 = 2'd1,
    S_STEP2 = 2'd2,
    S_STEP3 = 2'd3
  } state_e;

  // Resolved instruction kind, fixed at acceptance (degenerate moves/swaps fold to K_NOP).
  typedef enum logic [2:0] {
    K_NOP,
    K_MOVE,
    K_SWAP,
    K_LOAD,
    K_ILL
  } kind_e;

  localparam int SINGLE_STEPS = 1;
  localparam int SWAP_STEPS   = 3;

  function automatic state_e last_step(kind_e k);
    return (k == K_SWAP) ? state_e'(2'(SWAP_STEPS)) : state_e'(2'(SINGLE_STEPS));
  endfunction

endpackage

// File: rtl/reg_sel_decode.sv
// Register index plus enable to a one-hot-or-zero strobe vector.
module reg_sel_decode #(
  parameter int NUM_REGS = 2,
  parameter int ADDR_W   = 2
) (
  input  logic                en,
  input  logic [ADDR_W-1:0]   idx,
  output logic [NUM_REGS-1:0] sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && int'(idx) == i) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Sequences register in/out strobes onto a shared tristate bus for MOVE, SWAP and LOAD
// transfers, guaranteeing a single bus driver per cycle.
module bus_transfer_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NUM_REGS = 2,
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [1:0]          instr_op,
  input  logic [ADDR_W-1:0]   instr_src,
  input  logic [ADDR_W-1:0]   instr_dst,
  input  logic [DATA_W-1:0]   instr_imm,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                tmp_out,
  output logic                tmp_in,
  output logic                imm_out,
  output logic [DATA_W-1:0]   imm_data,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e              state_q, state_d;
  kind_e               kind_q, kind_d, new_kind;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic                armed_q;
  logic                accept, src_ok, dst_ok;
  logic                out_en, in_en;
  logic [ADDR_W-1:0]   out_idx, in_idx;

  // armed_q keeps instr_ready low until the first clock edge after reset release.
  assign instr_ready = (state_q == S_IDLE) && armed_q;
  assign accept      = instr_valid && instr_ready;
  assign src_ok      = int'(instr_src) < NUM_REGS;
  assign dst_ok      = int'(instr_dst) < NUM_REGS;

  always_comb begin
    new_kind = K_NOP;
    case (instr_op)
      OP_MOVE, OP_SWAP: begin
        if (!(src_ok && dst_ok))        new_kind = K_ILL;
        else if (instr_src == instr_dst) new_kind = K_NOP;
        else                            new_kind = (instr_op == OP_MOVE) ? K_MOVE : K_SWAP;
      end
      OP_LOAD: new_kind = dst_ok ? K_LOAD : K_ILL;
      default: new_kind = K_NOP;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        state_d = S_STEP1;
        kind_d  = new_kind;
        src_d   = instr_src;
        dst_d   = instr_dst;
        imm_d   = instr_imm;
      end
    end else if (state_q == last_step(kind_q)) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_e'(state_q + 2'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      kind_q  <= K_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    out_en  = 1'b0;
    in_en   = 1'b0;
    out_idx = src_q;
    in_idx  = dst_q;
    tmp_out = 1'b0;
    tmp_in  = 1'b0;
    imm_out = 1'b0;
    case (state_q)
      S_STEP1: begin
        case (kind_q)
          K_MOVE: begin out_en = 1'b1; in_en = 1'b1; end
          K_LOAD: begin imm_out = 1'b1; in_en = 1'b1; end
          K_SWAP: begin out_en = 1'b1; tmp_in = 1'b1; end
          default: ;
        endcase
      end
      S_STEP2: begin
        out_en  = 1'b1;
        out_idx = dst_q;
        in_en   = 1'b1;
        in_idx  = src_q;
      end
      S_STEP3: begin
        tmp_out = 1'b1;
        in_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = busy && (state_q == last_step(kind_q));
  assign err      = done && (kind_q == K_ILL);
  assign imm_data = imm_out ? imm_q : '0;

  reg_sel_decode #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_out_dec (
    .en (out_en),
    .idx(out_idx),
    .sel(reg_out)
  );

  reg_sel_decode #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_in_dec (
    .en (in_en),
    .idx(in_idx),
    .sel(reg_in)
  );

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench: the driver pushes expected per-cycle strobes from an instruction-level
// model; a negedge monitor pops them while busy and runs a small register/bus datapath.
module tb_bus_transfer_sequencer;

  logic       clk, rst;
  logic       instr_valid, instr_ready;
  logic [1:0] instr_op, instr_src, instr_dst;
  logic [3:0] instr_imm;
  logic [1:0] reg_out, reg_in;
  logic       tmp_out, tmp_in, imm_out;
  logic [3:0] imm_data;
  logic       busy, done, err;

  bus_transfer_sequencer #(.NUM_REGS(2), .ADDR_W(2), .DATA_W(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_src(instr_src), .instr_dst(instr_dst), .instr_imm(instr_imm),
    .reg_out(reg_out), .reg_in(reg_in), .tmp_out(tmp_out), .tmp_in(tmp_in),
    .imm_out(imm_out), .imm_data(imm_data), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [1:0] ro, ri;
    logic       to, ti, io;
    logic [3:0] id;
    logic       dn, er, rdy;
    logic [7:0] regs;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] m [2];
  logic [3:0] dp [2];
  logic [3:0] dp_tmp;
  logic [7:0] pre_vals;
  int         pre_seq = 0;
  int         pre_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_act();
    return {18'b0, reg_out, reg_in, tmp_out, tmp_in, imm_out, imm_data, done, err, instr_ready};
  endfunction

  function automatic logic [31:0] pack_exp(input exp_t e);
    return {18'b0, e.ro, e.ri, e.to, e.ti, e.io, e.id, e.dn, e.er, e.rdy};
  endfunction

  function automatic logic [1:0] oh(input logic [1:0] i);
    logic [1:0] r;
    r = '0;
    r[i[0]] = 1'b1;
    return r;
  endfunction

  // Monitor: owns the datapath registers; pops one expected record per busy cycle.
  always @(negedge clk) begin
    logic [3:0] bus;
    exp_t       rec;
    if (pre_seq != pre_seen) begin
      dp[0] = pre_vals[3:0];
      dp[1] = pre_vals[7:4];
      pre_seen = pre_seq;
    end
    if (!rst) begin
      check("reset_quiet", {pack_act(), busy}, '0);
    end else begin
      check("one_driver", 32'($countones({reg_out, tmp_out, imm_out}) <= 1), 1);
      check("in_out_overlap", reg_in & reg_out, 0);
      if (busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_busy", busy, 0);
        end else begin
          rec = exp_q.pop_front();
          check("strobes", pack_act(), pack_exp(rec));
          bus = reg_out[0] ? dp[0] : reg_out[1] ? dp[1] : tmp_out ? dp_tmp : imm_out ? imm_data : 4'h0;
          for (int i = 0; i < 2; i++) if (reg_in[i]) dp[i] = bus;
          if (tmp_in) dp_tmp = bus;
          if (rec.dn) check("regs_after", {dp[1], dp[0]}, rec.regs);
        end
      end else begin
        check("idle_quiet", {reg_out, reg_in, tmp_out, tmp_in, imm_out, imm_data, done, err}, 0);
      end
    end
  end

  task automatic preload(input logic [3:0] r0, input logic [3:0] r1);
    m[0] = r0;
    m[1] = r1;
    pre_vals = {r1, r0};
    pre_seq++;
    @(negedge clk);
  endtask

  task automatic push_last(input exp_t e, input logic er);
    e.dn = 1'b1;
    e.er = er;
    e.regs = {m[1], m[0]};
    exp_q.push_back(e);
  endtask

  // Instruction-level reference: expected strobe cycles and resulting register file.
  task automatic gen(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                     input logic [3:0] imm);
    exp_t       e;
    logic       ls, ld;
    logic [3:0] t;
    e  = '0;
    ls = (src < 2);
    ld = (dst < 2);
    case (op)
      2'b01: begin
        if (!(ls && ld)) push_last(e, 1'b1);
        else if (src == dst) push_last(e, 1'b0);
        else begin
          m[dst[0]] = m[src[0]];
          e.ro = oh(src);
          e.ri = oh(dst);
          push_last(e, 1'b0);
        end
      end
      2'b10: begin
        if (!(ls && ld)) push_last(e, 1'b1);
        else if (src == dst) push_last(e, 1'b0);
        else begin
          e.ro = oh(src); e.ti = 1'b1;
          exp_q.push_back(e);
          e = '0;
          e.ro = oh(dst); e.ri = oh(src);
          exp_q.push_back(e);
          t = m[src[0]];
          m[src[0]] = m[dst[0]];
          m[dst[0]] = t;
          e = '0;
          e.to = 1'b1; e.ri = oh(dst);
          push_last(e, 1'b0);
        end
      end
      2'b11: begin
        if (!ld) push_last(e, 1'b1);
        else begin
          m[dst[0]] = imm;
          e.io = 1'b1; e.id = imm; e.ri = oh(dst);
          push_last(e, 1'b0);
        end
      end
      default: push_last(e, 1'b0);
    endcase
  endtask

  task automatic start(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      check("accept_timeout", instr_ready, 1);
      return;
    end
    instr_op = op; instr_src = src; instr_dst = dst; instr_imm = imm;
    instr_valid = 1'b1;
    gen(op, src, dst, imm);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr_op  = 2'($urandom);
    instr_src = 2'($urandom);
    instr_dst = 2'($urandom);
    instr_imm = 4'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 10);
    check("done_timeout", instr_ready, 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [3:0] imm);
    start(op, src, dst, imm);
    wait_done();
  endtask

  function automatic logic [1:0] rand_idx();
    return ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m[0] = '0; m[1] = '0;
    dp[0] = '0; dp[1] = '0; dp_tmp = '0; pre_vals = '0;
    rst = 1'b1;
    instr_valid = 1'b1;
    instr_op = 2'b01; instr_src = 2'd0; instr_dst = 2'd1; instr_imm = 4'h0;
    #1 rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("reset_ready", instr_ready, 0);
      check("reset_busy", {busy, done, err}, 0);
    end
    rst = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1);

    preload(4'hA, 4'h0);
    issue(2'b01, 2'd0, 2'd1, 4'h0);
    preload(4'h3, 4'hC);
    issue(2'b10, 2'd0, 2'd1, 4'h0);
    issue(2'b11, 2'd0, 2'd1, 4'h5);
    issue(2'b01, 2'd2, 2'd0, 4'h0);
    issue(2'b10, 2'd1, 2'd1, 4'h0);
    issue(2'b00, 2'd3, 2'd3, 4'hF);
    issue(2'b11, 2'd3, 2'd3, 4'h9);
    issue(2'b01, 2'd1, 2'd1, 4'h0);
    issue(2'b11, 2'd0, 2'd0, 4'hE);

    // Abort a SWAP in its second step.
    preload(4'h6, 4'h9);
    start(2'b10, 2'd0, 2'd1, 4'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_quiet", {reg_out, reg_in, tmp_out, tmp_in, imm_out, done, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_abort", instr_ready, 1);
    preload(4'h7, 4'h1);
    issue(2'b01, 2'd1, 2'd0, 4'h0);

    for (int k = 0; k < 250; k++) begin
      if (k % 16 == 0) preload(4'($urandom), 4'($urandom));
      issue(2'($urandom_range(0, 3)), rand_idx(), rand_idx(), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
